// File: rtl/brom_fetch_bridge_pkg.sv
// Shared types for the bootrom fetch bridge: FSM states, the ROM word type,
// the word-offset constant and the byte-swap helper.
package sargantana_brom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } brom_state_e;

  typedef logic [63:0] brom_word_t;

  localparam int BROM_WORD_OFFSET = 3;
  localparam int TAG_W            = 40 - BROM_WORD_OFFSET;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/brom_fetch_bridge_word_buffer.sv
// One-entry 64b ROM word buffer: tag/valid/data, hit compare against the
// incoming fetch, and 32b word select with optional byte swap.
module brom_word_buffer
  import sargantana_brom_pkg::*;
#(
  parameter bit SwapEndian = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_l,
  input  logic             i_fill,
  input  logic             i_inval,
  input  logic [TAG_W-1:0] i_fill_tag,
  input  logic [63:0]      i_fill_data,
  input  logic [TAG_W-1:0] i_lookup_tag,
  input  logic             i_sel_hi,
  output logic             o_hit,
  output logic [31:0]      o_word
);

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  brom_word_t       r_data;
  logic [31:0]      w_sel;

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end
  end

  // Tag and data only matter while r_valid is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (i_fill) begin
      r_tag  <= i_fill_tag;
      r_data <= i_fill_data;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign w_sel  = i_sel_hi ? r_data[63:32] : r_data[31:0];
  assign o_word = SwapEndian ? bswap32(w_sel) : w_sel;

endmodule

// File: rtl/brom_fetch_bridge.sv
// Bootrom fetch bridge: range-checks core fetches, serves hits from a one-word
// buffer and otherwise reads the 64b ROM macro under a bounded wait.
module brom_fetch_bridge
  import sargantana_brom_pkg::*;
#(
  parameter logic [63:0] BromBase      = 64'h00C0000000,
  parameter logic [63:0] BromEnd       = 64'h00C0010000,
  parameter int          RomAddrWidth  = 13,
  parameter int          TimeoutCycles = 64,
  parameter bit          SwapEndian    = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_l,
  input  logic                    brom_req_valid_i,
  input  logic [39:0]             brom_req_address_i,
  output logic                    brom_resp_valid_o,
  output logic [31:0]             brom_resp_data_o,
  output logic                    rom_req_o,
  output logic [RomAddrWidth-1:0] rom_addr_o,
  input  logic                    rom_rvalid_i,
  input  logic [63:0]             rom_rdata_i,
  output logic                    err_o,
  output logic                    drop_o
);

  localparam int TMR_W = $clog2(TimeoutCycles + 1);

  brom_state_e             r_state;
  logic [TAG_W-1:0]        r_req_tag;
  logic                    r_req_hi;
  logic                    r_err_flag;
  logic [TMR_W-1:0]        r_timer;
  logic                    r_resp_valid;
  logic [31:0]             r_resp_data;
  logic                    r_rom_req;
  logic [RomAddrWidth-1:0] r_rom_addr;
  logic                    r_err;

  logic [63:0] w_addr64;
  logic        w_in_range;
  logic        w_hit;
  logic        w_fill;
  logic        w_timeout;
  logic [31:0] w_word;

  assign w_addr64   = {24'd0, brom_req_address_i};
  assign w_in_range = (w_addr64 >= BromBase) && (w_addr64 < BromEnd);
  // ROM data is only accepted in WAIT; stale or late beats never touch the buffer.
  assign w_fill     = (r_state == ST_WAIT) && rom_rvalid_i;
  assign w_timeout  = (r_state == ST_WAIT) && !rom_rvalid_i &&
                      (r_timer == TMR_W'(TimeoutCycles - 1));

  brom_word_buffer #(
    .SwapEndian(SwapEndian)
  ) u_buf (
    .clk_i       (clk_i),
    .reset_l     (reset_l),
    .i_fill      (w_fill),
    .i_inval     (w_timeout),
    .i_fill_tag  (r_req_tag),
    .i_fill_data (rom_rdata_i),
    .i_lookup_tag(brom_req_address_i[39:BROM_WORD_OFFSET]),
    .i_sel_hi    (r_req_hi),
    .o_hit       (w_hit),
    .o_word      (w_word)
  );

  always_ff @(posedge clk_i) begin
    if (r_state == ST_IDLE && brom_req_valid_i) begin
      r_req_tag <= brom_req_address_i[39:BROM_WORD_OFFSET];
      r_req_hi  <= brom_req_address_i[2];
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      r_state      <= ST_IDLE;
      r_err_flag   <= 1'b0;
      r_timer      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_rom_req    <= 1'b0;
      r_rom_addr   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_rom_req    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (brom_req_valid_i) begin
            r_err_flag <= !w_in_range;
            if (!w_in_range || w_hit) begin
              r_state <= ST_RESP;
            end else begin
              // Strobe is raised on entry so it is high exactly while in ISSUE.
              r_rom_req  <= 1'b1;
              r_rom_addr <= RomAddrWidth'((w_addr64 - BromBase) >> BROM_WORD_OFFSET);
              r_state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rom_rvalid_i) begin
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_err_flag <= 1'b1;
            r_state    <= ST_RESP;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP: begin
          r_resp_valid <= 1'b1;
          r_err        <= r_err_flag;
          r_resp_data  <= r_err_flag ? 32'd0 : w_word;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign brom_resp_valid_o = r_resp_valid;
  assign brom_resp_data_o  = r_resp_data;
  assign rom_req_o         = r_rom_req;
  assign rom_addr_o        = r_rom_addr;
  assign err_o             = r_err;
  assign drop_o            = brom_req_valid_i && (r_state != ST_IDLE);

endmodule

// File: tb/tb_brom_fetch_bridge.sv
// Bench for brom_fetch_bridge: two instances (plain and byte-swapped) share one
// stimulus stream and are checked against a transaction-level buffer model.
module tb_brom_fetch_bridge;

  localparam int          TO   = 8;
  localparam logic [63:0] BASE = 64'h00C0000000;
  localparam logic [63:0] ENDA = 64'h00C0010000;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        req_valid;
  logic [39:0] req_addr;
  logic        rvalid;
  logic [63:0] rdata;

  logic        resp_valid0, resp_valid1, rom_req0, rom_req1;
  logic        err0, err1, drop0, drop1;
  logic [31:0] resp_data0, resp_data1;
  logic [12:0] rom_addr0, rom_addr1;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_valid;
  logic [36:0] m_tag;
  logic [63:0] m_data;

  always #5 clk = ~clk;

  brom_fetch_bridge #(.TimeoutCycles(TO), .SwapEndian(1'b0)) u_dut0 (
    .clk_i(clk), .reset_l(reset_l), .brom_req_valid_i(req_valid),
    .brom_req_address_i(req_addr), .brom_resp_valid_o(resp_valid0),
    .brom_resp_data_o(resp_data0), .rom_req_o(rom_req0), .rom_addr_o(rom_addr0),
    .rom_rvalid_i(rvalid), .rom_rdata_i(rdata), .err_o(err0), .drop_o(drop0));

  brom_fetch_bridge #(.TimeoutCycles(TO), .SwapEndian(1'b1)) u_dut1 (
    .clk_i(clk), .reset_l(reset_l), .brom_req_valid_i(req_valid),
    .brom_req_address_i(req_addr), .brom_resp_valid_o(resp_valid1),
    .brom_resp_data_o(resp_data1), .rom_req_o(rom_req1), .rom_addr_o(rom_addr1),
    .rom_rvalid_i(rvalid), .rom_rdata_i(rdata), .err_o(err1), .drop_o(drop1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // One fetch. lat = cycles from the ROM strobe to rvalid (0 = ROM silent).
  // drop_at > 0 drives an extra request on that cycle, while the bridge is busy.
  task automatic fetch(input logic [39:0] addr, input int lat, input logic [63:0] data,
                       input int drop_at);
    logic [63:0] a64, off, src;
    logic [31:0] ew, d0, d1;
    logic [12:0] raddr;
    logic        inr, hit, miss, got_data, exp_err, e0, e1;
    int          exp_cyc, nreq0, nreq1, nresp0, nresp1, req_cyc, resp_cyc;
    a64      = {24'd0, addr};
    off      = (a64 - BASE) >> 3;
    inr      = (a64 >= BASE) && (a64 < ENDA);
    hit      = inr && m_valid && (m_tag == addr[39:3]);
    miss     = inr && !hit;
    got_data = miss && (lat >= 1) && (lat <= TO);
    exp_err  = !inr || (miss && !got_data);
    exp_cyc  = !miss ? 2 : (got_data ? 3 + lat : 3 + TO);
    src      = hit ? m_data : data;
    ew       = exp_err ? 32'd0 : (addr[2] ? src[63:32] : src[31:0]);
    nreq0 = 0; nreq1 = 0; nresp0 = 0; nresp1 = 0; req_cyc = -1; resp_cyc = -1;
    d0 = '0; d1 = '0; e0 = 1'b0; e1 = 1'b0; raddr = '0;

    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    #1 chk("drop_idle", {drop1, drop0}, 2'b00);
    for (int k = 1; k <= TO + 10; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      rvalid    = 1'b0;
      if (rom_req0) begin nreq0++; req_cyc = k; raddr = rom_addr0; end
      if (rom_req1) nreq1++;
      if (resp_valid0) begin nresp0++; resp_cyc = k; d0 = resp_data0; e0 = err0; end
      if (resp_valid1) begin nresp1++; d1 = resp_data1; e1 = err1; end
      if (lat > 0 && req_cyc > 0 && k == req_cyc + lat) begin
        rvalid = 1'b1;
        rdata  = data;
      end
      if (k == drop_at) begin
        req_valid = 1'b1;
        req_addr  = addr ^ 40'h8;
        #1 chk("drop_busy", {drop1, drop0}, 2'b11);
      end
    end

    chk("rom_req_cnt0", nreq0, miss ? 1 : 0);
    chk("rom_req_cnt1", nreq1, miss ? 1 : 0);
    if (miss) begin
      chk("rom_req_cyc", req_cyc, 1);
      chk("rom_addr", raddr, off[12:0]);
    end
    chk("resp_cnt0", nresp0, 1);
    chk("resp_cnt1", nresp1, 1);
    chk("resp_cyc", resp_cyc, exp_cyc);
    chk("data0", d0, ew);
    chk("data1", d1, swap(ew));
    chk("err0", e0, exp_err);
    chk("err1", e1, exp_err);

    if (got_data) begin
      m_valid = 1'b1;
      m_tag   = addr[39:3];
      m_data  = data;
    end else if (miss) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic [39:0] a;
    int          nlate;
    reset_l = 1'b0; req_valid = 1'b0; req_addr = '0; rvalid = 1'b0; rdata = '0;
    m_valid = 1'b0; m_tag = '0; m_data = '0;
    #12;
    chk("rst_resp_valid", {resp_valid1, resp_valid0}, 2'b00);
    chk("rst_data", {resp_data1, resp_data0}, 64'd0);
    chk("rst_rom", {rom_req1, rom_req0, rom_addr1, rom_addr0}, 28'd0);
    chk("rst_err_drop", {err1, err0, drop1, drop0}, 4'd0);
    @(negedge clk);
    reset_l = 1'b1;

    // Miss then hit, both byte orders
    fetch(40'hC0000000, 2, 64'h11223344_AABBCCDD, 0);
    fetch(40'hC0000004, 0, 64'h0, 0);
    // Out of range and window edges
    fetch(40'h0080000000, 3, 64'h5555_6666_7777_8888, 0);
    fetch(ENDA[39:0], 3, 64'h5555_6666_7777_8888, 0);
    fetch(BASE[39:0] - 40'd4, 3, 64'h5555_6666_7777_8888, 1);
    fetch(ENDA[39:0] - 40'd4, 4, 64'h0102_0304_0506_0708, 0);
    // Timeout, then the same word misses again
    fetch(40'hC0000100, 0, 64'h0, 0);
    fetch(40'hC0000100, TO, 64'hCAFE_F00D_DEAD_BEEF, 0);
    // Late ROM data after a timeout is discarded
    fetch(40'hC0000180, TO + 1, 64'h9999_8888_7777_6666, 0);
    // Busy drop during WAIT, then stale rvalid in IDLE
    fetch(40'hC0000200, 5, 64'hA1A2A3A4_B1B2B3B4, 2);
    @(negedge clk); rvalid = 1'b1; rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk); rvalid = 1'b0;
    fetch(40'hC0000204, 0, 64'h0, 0);
    fetch(40'hC0000200, 0, 64'h0, 0);

    // Reset while waiting on the ROM
    @(negedge clk); req_valid = 1'b1; req_addr = 40'hC0000400;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_l = 1'b0;
    #1;
    chk("arst_data", {resp_data1, resp_data0}, 64'd0);
    chk("arst_rom_addr", {rom_addr1, rom_addr0}, 26'd0);
    chk("arst_ctrl", {resp_valid1, resp_valid0, rom_req1, rom_req0, err1, err0}, 6'd0);
    @(negedge clk); reset_l = 1'b1;
    m_valid = 1'b0;
    @(negedge clk); rvalid = 1'b1; rdata = 64'h7777_7777_7777_7777;
    nlate = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rvalid = 1'b0;
      if (resp_valid0 || resp_valid1 || rom_req0 || rom_req1) nlate++;
    end
    chk("late_after_reset", nlate, 0);
    fetch(40'hC0000400, 3, 64'h1357_9BDF_2468_ACE0, 0);
    fetch(40'hC0000204, 2, 64'h0F0E_0D0C_0B0A_0908, 0);

    // Randomized traffic over a few hot words plus out-of-range addresses
    for (int i = 0; i < 40; i++) begin
      int cls;
      int idx;
      cls = $urandom_range(0, 9);
      idx = $urandom_range(0, 3);
      if (cls == 0)      a = BASE[39:0] - 40'(8 * $urandom_range(1, 1000)) + 40'(4 * $urandom_range(0, 1));
      else if (cls == 1) a = ENDA[39:0] + 40'(4 * $urandom_range(0, 100));
      else               a = BASE[39:0] + 40'((idx == 3 ? 13'h1FFF : idx) * 8) + 40'(4 * $urandom_range(0, 1));
      fetch(a, $urandom_range(0, TO + 3), {$urandom, $urandom}, $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
